// File: rtl/xor_acc_pkg.sv
// Shared definitions for the streaming XOR accumulator.
// State encoding and counter-width derivation.
package xor_acc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    function automatic int cnt_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/xor_acc_bh_xor_word.sv
// Combinational WIDTH-bit bitwise XOR, the word-wide form of the gate.
module xor_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y
);

    assign Y = A ^ B;

endmodule

// File: rtl/xor_acc_bh.sv
// Streaming XOR accumulator with registered result handshake.
// Optional OUT_PARITY port when XOR_ACC_PARITY_EN is defined.
module xor_acc_bh
    import xor_acc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = cnt_width(MAX_WORDS)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_LAST,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [CNT_W-1:0] OUT_COUNT,
    output logic             OUT_ERR
`ifdef XOR_ACC_PARITY_EN
    ,
    output logic             OUT_PARITY
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_err_q, out_err_d;
    logic             out_parity_q, out_parity_d;

    logic             accept;
    logic             closing;
    logic [WIDTH-1:0] xor_a;
    logic [WIDTH-1:0] xor_y;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    assign IN_READY = RST_N && (state_q != S_HOLD);
    assign accept   = IN_VALID && IN_READY;

    // Zeroing the XOR operand in IDLE lets one instance serve load and fold.
    assign xor_a    = (state_q == S_IDLE) ? '0 : acc_q;
    assign cnt_base = (state_q == S_IDLE) ? '0 : cnt_q;
    assign cnt_next = cnt_base + CNT_W'(1);
    assign closing  = IN_LAST || (cnt_next == CNT_W'(MAX_WORDS));

    xor_word #(
        .WIDTH (WIDTH)
    ) u_xor (
        .A (xor_a),
        .B (IN_DATA),
        .Y (xor_y)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        out_err_d    = out_err_q;
        out_parity_d = out_parity_q;
        unique case (state_q)
            S_IDLE, S_ACC: begin
                if (accept) begin
                    acc_d = xor_y;
                    cnt_d = cnt_next;
                    if (closing) begin
                        state_d      = S_HOLD;
                        out_valid_d  = 1'b1;
                        out_data_d   = xor_y;
                        out_count_d  = cnt_next;
                        out_err_d    = !IN_LAST;
                        out_parity_d = ^xor_y;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_HOLD: begin
                if (OUT_READY) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_err_q    <= 1'b0;
            out_parity_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_err_q    <= out_err_d;
            out_parity_q <= out_parity_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_COUNT = out_count_q;
    assign OUT_ERR   = out_err_q;

`ifdef XOR_ACC_PARITY_EN
    assign OUT_PARITY = out_parity_q;
`else
    logic unused_parity;
    assign unused_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_xor_acc_bh.sv
// Directed bench for xor_acc_bh (WIDTH=8, MAX_WORDS=4).
module tb_xor_acc_bh;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] IN_DATA;
    logic       IN_LAST;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] OUT_DATA;
    logic [2:0] OUT_COUNT;
    logic       OUT_ERR;
`ifdef XOR_ACC_PARITY_EN
    logic       OUT_PARITY;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    xor_acc_bh #(
        .WIDTH     (8),
        .MAX_WORDS (4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .IN_LAST   (IN_LAST),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_COUNT (OUT_COUNT),
        .OUT_ERR   (OUT_ERR)
`ifdef XOR_ACC_PARITY_EN
        ,
        .OUT_PARITY(OUT_PARITY)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        IN_VALID = 1'b1;
        IN_DATA  = d;
        IN_LAST  = l;
        tick();
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        IN_DATA  = 8'hxx;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00;
        IN_LAST = 1'b0; OUT_READY = 1'b0;
        tick(); tick();
        n_checks++;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'h00 ||
            OUT_COUNT !== 3'd0 || OUT_ERR !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_out got v=%b d=%h c=%0d e=%b exp 0 0 0 0",
                     OUT_VALID, OUT_DATA, OUT_COUNT, OUT_ERR);
        end
        n_checks++;
        if (IN_READY !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready got=%b exp=0", IN_READY);
        end
`ifdef XOR_ACC_PARITY_EN
        n_checks++;
        if (OUT_PARITY !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_parity got=%b exp=0", OUT_PARITY);
        end
`endif
        RST_N = 1'b1;
        #1;
        n_checks++;
        if (IN_READY !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_ready got=%b exp=1", IN_READY);
        end
    endtask

    task automatic test_basic();
        OUT_READY = 1'b1;
        beat(8'hA5, 1'b0);
        n_checks++;
        if (OUT_VALID !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_early_valid got=%b exp=0", OUT_VALID);
        end
        beat(8'h3C, 1'b0);
        beat(8'hFF, 1'b1);
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h66 ||
            OUT_COUNT !== 3'd3 || OUT_ERR !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_out got v=%b d=%h c=%0d e=%b exp 1 66 3 0",
                     OUT_VALID, OUT_DATA, OUT_COUNT, OUT_ERR);
        end
        n_checks++;
        if (IN_READY !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_hold_ready got=%b exp=0", IN_READY);
        end
        tick();
        n_checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_drain got v=%b r=%b exp v=0 r=1",
                     OUT_VALID, IN_READY);
        end
    endtask

    task automatic test_single();
        OUT_READY = 1'b1;
        beat(8'h07, 1'b1);
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h07 ||
            OUT_COUNT !== 3'd1 || OUT_ERR !== 1'b0) begin
            n_errors++;
            $display("FAIL single_out got v=%b d=%h c=%0d e=%b exp 1 07 1 0",
                     OUT_VALID, OUT_DATA, OUT_COUNT, OUT_ERR);
        end
`ifdef XOR_ACC_PARITY_EN
        n_checks++;
        if (OUT_PARITY !== 1'b1) begin
            n_errors++;
            $display("FAIL single_parity got=%b exp=1", OUT_PARITY);
        end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        OUT_READY = 1'b0;
        beat(8'h12, 1'b0);
        beat(8'h34, 1'b1);
        IN_VALID = 1'b1; IN_DATA = 8'hAA; IN_LAST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h26 ||
                OUT_COUNT !== 3'd2 || IN_READY !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h c=%0d r=%b exp 1 26 2 0",
                         i, OUT_VALID, OUT_DATA, OUT_COUNT, IN_READY);
            end
            tick();
        end
        IN_VALID = 1'b0; IN_LAST = 1'b0;
        OUT_READY = 1'b1;
        n_checks++;
        if (IN_READY !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_handshake_ready got=%b exp=0", IN_READY);
        end
        tick();
        n_checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release got v=%b r=%b exp v=0 r=1",
                     OUT_VALID, IN_READY);
        end
        beat(8'h01, 1'b1);
        n_checks++;
        if (OUT_DATA !== 8'h01 || OUT_COUNT !== 3'd1) begin
            n_errors++;
            $display("FAIL bp_not_consumed got d=%h c=%0d exp 01 1",
                     OUT_DATA, OUT_COUNT);
        end
        tick();
    endtask

    task automatic test_overflow();
        OUT_READY = 1'b1;
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h04, 1'b0);
        n_checks++;
        if (OUT_VALID !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_early_valid got=%b exp=0", OUT_VALID);
        end
        beat(8'h08, 1'b0);
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h0F ||
            OUT_COUNT !== 3'd4 || OUT_ERR !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_out got v=%b d=%h c=%0d e=%b exp 1 0F 4 1",
                     OUT_VALID, OUT_DATA, OUT_COUNT, OUT_ERR);
        end
        tick();
        beat(8'h03, 1'b1);
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h03 ||
            OUT_COUNT !== 3'd1 || OUT_ERR !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_fresh got v=%b d=%h c=%0d e=%b exp 1 03 1 0",
                     OUT_VALID, OUT_DATA, OUT_COUNT, OUT_ERR);
        end
        tick();
    endtask

    task automatic test_gaps();
        OUT_READY = 1'b1;
        beat(8'h11, 1'b0);
        IN_DATA = 8'hEE; IN_LAST = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (OUT_VALID !== 1'b0) begin
            n_errors++;
            $display("FAIL gap_valid got=%b exp=0", OUT_VALID);
        end
        beat(8'h22, 1'b1);
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h33 ||
            OUT_COUNT !== 3'd2 || OUT_ERR !== 1'b0) begin
            n_errors++;
            $display("FAIL gap_out got v=%b d=%h c=%0d e=%b exp 1 33 2 0",
                     OUT_VALID, OUT_DATA, OUT_COUNT, OUT_ERR);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        OUT_READY = 1'b1;
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b0);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        n_checks++;
        if (OUT_VALID !== 1'b0 || OUT_COUNT !== 3'd0) begin
            n_errors++;
            $display("FAIL rst_mid_out got v=%b c=%0d exp v=0 c=0",
                     OUT_VALID, OUT_COUNT);
        end
        beat(8'h0F, 1'b1);
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h0F ||
            OUT_COUNT !== 3'd1 || OUT_ERR !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_fresh got v=%b d=%h c=%0d e=%b exp 1 0F 1 0",
                     OUT_VALID, OUT_DATA, OUT_COUNT, OUT_ERR);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_overflow();
        test_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
